// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the PIO bus initiator and its divider sub-module:
//   - RESET_SIG : port declaration macro for the asynchronous active-low reset
//   - pio_state_e : initiator FSM encoding (3 bits)
//   - default data/address width, clk_div ratio and WAIT timeout
// -----------------------------------------------------------------------------
`ifndef RESET_SIG
`define RESET_SIG input logic rst_n
`endif

package pio_pkg;

  localparam int PIO_NBITS_DEF      = 32;
  localparam int DIV_RATIO_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STROBE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_DRAIN  = 3'd4
  } pio_state_e;

endpackage

// File: rtl/pio_clk_div_gen.sv
// -----------------------------------------------------------------------------
// pio_clk_div_gen
// Free-running divider producing the clk_div pacing strobe for PIO slaves.
// clk_div is high for one clk cycle out of every DIV_RATIO (2..16).
// Ports:
//   clk     in  core clock
//   rst_n   in  asynchronous active-low reset
//   clk_div out registered strobe, high while the count equals DIV_RATIO-1
// -----------------------------------------------------------------------------
module pio_clk_div_gen
  import pio_pkg::*;
#(
  parameter int DIV_RATIO = DIV_RATIO_DEF
) (
  input  logic clk,
  `RESET_SIG,
  output logic clk_div
);

  localparam int            CW   = $clog2(DIV_RATIO);
  localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_div_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // The strobe is registered from the next count so that it lines up exactly
  // with the cycle in which the count sits at DIV_RATIO-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= (cnt_d == LAST);
    end
  end

  assign clk_div = clk_div_q;

endmodule

// File: rtl/pio_bus_initiator.sv
// -----------------------------------------------------------------------------
// pio_bus_initiator
// PIO bus master: accepts one host read/write command at a time, drives the
// reg_* strobes towards the PIO slaves, waits for pio_ack / pio_rvalid (or a
// timeout) and returns a single-cycle response. Also generates clk_div.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   clk_div                         slave pacing strobe
//   cmd_valid/ready/rnw/addr/wdata  host command channel (ready only in IDLE)
//   rsp_valid/rdata/err             one-cycle response, err = timeout
//   reg_bs/wr/rd/addr/din           PIO register bus towards the slaves
//   pio_ack/rvalid/rdata            slave completions
// All outputs are registered.
// -----------------------------------------------------------------------------
module pio_bus_initiator
  import pio_pkg::*;
#(
  parameter int PIO_NBITS      = PIO_NBITS_DEF,
  parameter int DIV_RATIO      = DIV_RATIO_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  `RESET_SIG,
  output logic                 clk_div,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rnw,
  input  logic [PIO_NBITS-1:0] cmd_addr,
  input  logic [PIO_NBITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [PIO_NBITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 reg_bs,
  output logic                 reg_wr,
  output logic                 reg_rd,
  output logic [PIO_NBITS-1:0] reg_addr,
  output logic [PIO_NBITS-1:0] reg_din,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  pio_state_e           state_q, state_d;
  logic                 rnw_q, rnw_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 div_seen_q, div_seen_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [PIO_NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 reg_bs_q, reg_bs_d;
  logic                 reg_wr_q, reg_wr_d;
  logic                 reg_rd_q, reg_rd_d;
  logic [PIO_NBITS-1:0] reg_addr_q, reg_addr_d;
  logic [PIO_NBITS-1:0] reg_din_q, reg_din_d;

  logic clk_div_w;
  logic done_w;

  pio_clk_div_gen #(
    .DIV_RATIO (DIV_RATIO)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_div (clk_div_w)
  );

  // A stray pio_ack during a read must not complete it.
  assign done_w = rnw_q ? pio_rvalid : pio_ack;

  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    tmo_cnt_d   = tmo_cnt_q;
    div_seen_d  = div_seen_q;
    reg_addr_d  = reg_addr_q;
    reg_din_d   = reg_din_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is only ever high in IDLE, so it doubles as the handshake.
        if (cmd_valid && cmd_ready_q) begin
          rnw_d      = cmd_rnw;
          reg_addr_d = cmd_addr;
          reg_din_d  = cmd_wdata;
          reg_rd_d   = cmd_rnw;
          reg_wr_d   = ~cmd_rnw;
          state_d    = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Completion is tested first so that it wins over a coincident timeout.
        if (done_w) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rnw_q ? pio_rdata : '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d    = ST_DRAIN;
        div_seen_d = 1'b0;
      end
      ST_DRAIN: begin
        // Slaves only update their ack state on clk_div, so wait for at least
        // one pulse inside DRAIN and for both completion lines to be low.
        if (clk_div_w) div_seen_d = 1'b1;
        if (!pio_ack && !pio_rvalid && (div_seen_q || clk_div_w)) begin
          state_d   = ST_IDLE;
          tmo_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    reg_bs_d    = (state_d == ST_STROBE) || (state_d == ST_WAIT);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnw_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      div_seen_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      reg_bs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      tmo_cnt_q   <= tmo_cnt_d;
      div_seen_q  <= div_seen_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      reg_bs_q    <= reg_bs_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_din_q   <= reg_din_d;
    end
  end

  assign clk_div   = clk_div_w;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign reg_bs    = reg_bs_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_din   = reg_din_q;

endmodule

// File: tb/tb_pio_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_pio_bus_initiator
// Directed bench for pio_bus_initiator: inputs are driven and outputs sampled
// on the falling clock edge; the slave side is played by hand in each step.
// -----------------------------------------------------------------------------
`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_pio_bus_initiator;

  localparam int W    = 32;
  localparam int T    = 1024;
  localparam int DIVR = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_div;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_rnw = 1'b0;
  logic [W-1:0] cmd_addr = '0;
  logic [W-1:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic         reg_bs, reg_wr, reg_rd;
  logic [W-1:0] reg_addr, reg_din;
  logic         pio_ack = 1'b0;
  logic         pio_rvalid = 1'b0;
  logic [W-1:0] pio_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pio_bus_initiator #(
    .PIO_NBITS      (W),
    .DIV_RATIO      (DIVR),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div    (clk_div),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rnw    (cmd_rnw),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .reg_bs     (reg_bs),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_din    (reg_din),
    .pio_ack    (pio_ack),
    .pio_rvalid (pio_rvalid),
    .pio_rdata  (pio_rdata)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) at the falling edge for cmd_ready.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, cmd_ready, 1'b1)
  endtask

  // Present one command at a falling edge where cmd_ready is high; returns at
  // the next falling edge (the STROBE cycle) with cmd_valid dropped.
  task automatic issue(input logic rnw, input logic [W-1:0] a, input logic [W-1:0] d);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic bad;
    int   n;
    int   pulses;
    int   period;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    `CHK("rst_cmd_ready", cmd_ready, 1'b0)
    `CHK("rst_rsp_valid", rsp_valid, 1'b0)
    `CHK("rst_reg_bs", reg_bs, 1'b0)
    `CHK("rst_clk_div", clk_div, 1'b0)
    `CHK("rst_reg_addr", reg_addr, 32'h0)
    rst_n = 1'b1;
    wait_ready("ready_after_reset");

    // ---- 1: write, slave acks 5 cycles after reg_wr ----
    issue(1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    `CHK("wr_strobe_wr", reg_wr, 1'b1)
    `CHK("wr_strobe_rd", reg_rd, 1'b0)
    `CHK("wr_strobe_bs", reg_bs, 1'b1)
    `CHK("wr_addr", reg_addr, 32'h0000_0100)
    `CHK("wr_din", reg_din, 32'hDEAD_BEEF)
    bad = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (reg_bs !== 1'b1 || reg_wr !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      if (k == 6) pio_ack = 1'b1;
    end
    `CHK("wr_wait_hold", bad, 1'b0)
    @(negedge clk);
    pio_ack = 1'b0;
    `CHK("wr_rsp_valid", rsp_valid, 1'b1)
    `CHK("wr_rsp_err", rsp_err, 1'b0)
    `CHK("wr_rsp_rdata", rsp_rdata, 32'h0)
    `CHK("wr_resp_bs", reg_bs, 1'b0)
    @(negedge clk);
    `CHK("wr_rsp_pulse", rsp_valid, 1'b0)
    `CHK("wr_drain_ready", cmd_ready, 1'b0)
    wait_ready("ready_after_wr");

    // ---- 2: read, rvalid on a clk_div tick ----
    issue(1'b1, 32'h0000_0200, 32'h0);
    `CHK("rd_strobe_rd", reg_rd, 1'b1)
    `CHK("rd_strobe_wr", reg_wr, 1'b0)
    @(negedge clk);
    `CHK("rd_rd_one_cycle", reg_rd, 1'b0)
    n = 0;
    while (clk_div !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    `CHK("rd_clk_div_seen", clk_div, 1'b1)
    pio_rvalid = 1'b1;
    pio_rdata  = 32'h1234_5678;
    @(negedge clk);
    pio_rvalid = 1'b0;
    pio_rdata  = '0;
    `CHK("rd_rsp_valid", rsp_valid, 1'b1)
    `CHK("rd_rsp_rdata", rsp_rdata, 32'h1234_5678)
    `CHK("rd_rsp_err", rsp_err, 1'b0)
    wait_ready("ready_after_rd");

    // ---- 3: read timeout (stray pio_ack during a read is ignored) ----
    issue(1'b1, 32'h0000_0400, 32'h0);
    bad = 1'b0;
    for (int k = 1; k <= T + 1; k++) begin
      if (k > 1) @(negedge clk);
      pio_ack = (k == 5);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    `CHK("tmo_no_early_rsp", bad, 1'b0)
    `CHK("tmo_last_wait_bs", reg_bs, 1'b1)
    @(negedge clk);
    `CHK("tmo_rsp_valid", rsp_valid, 1'b1)
    `CHK("tmo_rsp_err", rsp_err, 1'b1)
    `CHK("tmo_rsp_rdata", rsp_rdata, 32'h0)
    `CHK("tmo_resp_bs", reg_bs, 1'b0)
    wait_ready("ready_after_tmo");

    // ---- 4: pio_ack held through DRAIN, next command waiting ----
    cmd_valid = 1'b1;
    cmd_rnw   = 1'b0;
    cmd_addr  = 32'h0000_0300;
    cmd_wdata = 32'h0000_0055;
    @(negedge clk);
    `CHK("hold_first_wr", reg_wr, 1'b1)
    @(negedge clk);
    pio_ack = 1'b1;
    @(negedge clk);
    `CHK("hold_first_rsp", rsp_valid, 1'b1)
    @(negedge clk);
    bad = 1'b0;
    pulses = 0;
    n = 0;
    while (pulses < 3 && n < 40) begin
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || reg_bs !== 1'b0 || reg_wr !== 1'b0)
        bad = 1'b1;
      if (clk_div === 1'b1) pulses++;
      if (pulses < 3) @(negedge clk);
      n++;
    end
    pio_ack = 1'b0;
    `CHK("hold_drain_quiet", bad, 1'b0)
    `CHK("hold_pulses", pulses, 3)
    @(negedge clk);
    `CHK("hold_ready_up", cmd_ready, 1'b1)
    @(negedge clk);
    cmd_valid = 1'b0;
    `CHK("hold_second_wr", reg_wr, 1'b1)
    `CHK("hold_second_addr", reg_addr, 32'h0000_0300)
    @(negedge clk);
    `CHK("hold_no_spurious", rsp_valid, 1'b0)
    pio_ack = 1'b1;
    @(negedge clk);
    pio_ack = 1'b0;
    `CHK("hold_second_rsp", rsp_valid, 1'b1)
    wait_ready("ready_after_hold");

    // ---- 5: rvalid in the same cycle the timeout expires ----
    issue(1'b1, 32'h0000_0500, 32'h0);
    for (int k = 2; k <= T + 1; k++) @(negedge clk);
    `CHK("race_no_rsp_yet", rsp_valid, 1'b0)
    pio_rvalid = 1'b1;
    pio_rdata  = 32'hA5A5_5A5A;
    @(negedge clk);
    pio_rvalid = 1'b0;
    pio_rdata  = '0;
    `CHK("race_rsp_valid", rsp_valid, 1'b1)
    `CHK("race_rsp_err", rsp_err, 1'b0)
    `CHK("race_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A)
    wait_ready("ready_after_race");

    // ---- 6: reset asserted during WAIT of a write ----
    issue(1'b0, 32'h0000_0600, 32'h0000_00AA);
    @(negedge clk);
    `CHK("rstw_wait_bs", reg_bs, 1'b1)
    #1 rst_n = 1'b0;
    #1;
    `CHK("rstw_bs", reg_bs, 1'b0)
    `CHK("rstw_wr", reg_wr, 1'b0)
    `CHK("rstw_rsp_valid", rsp_valid, 1'b0)
    `CHK("rstw_cmd_ready", cmd_ready, 1'b0)
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    @(negedge clk);
    `CHK("rstw_ready_after", cmd_ready, 1'b1)
    if (clk_div !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
    @(negedge clk);
    if (clk_div !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
    `CHK("rstw_div_quiet_no_rsp", bad, 1'b0)
    @(negedge clk);
    `CHK("rstw_first_div", clk_div, 1'b1)
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (clk_div !== 1'b1 && period < 32);
    `CHK("rstw_div_period", period, DIVR)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Read and write strobes must never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!(reg_rd === 1'b1 && reg_wr === 1'b1)) else begin
        fails++;
        $error("FAIL rd_wr_overlap observed=%0h expected=%0h", {reg_rd, reg_wr}, 2'b00);
      end
    end
  end

endmodule
